hdmi_timing_ctrl: RTL and testbench

//  Video timing sequencer that drives the HDMI output stage.

---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/timing_axis_cnt.sv | 58 +++++
 rtl/hdmi_timing_ctrl.sv | 147 ++++++++++++++
 tb/tb_hdmi_timing_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 1280x720@60 timing constants, FSM/region types and the underflow colour-bar lookup
// for the HDMI timing controller.
package video_timing_pkg;

  localparam int VT_H_ACTIVE = 1280;
  localparam int VT_H_FP     = 110;
  localparam int VT_H_SYNC   = 40;
  localparam int VT_H_BP     = 220;
  localparam int VT_V_ACTIVE = 720;
  localparam int VT_V_FP     = 5;
  localparam int VT_V_SYNC   = 5;
  localparam int VT_V_BP     = 20;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} vt_state_e;

  // Region order along either axis; prefixed so they never collide with the axis parameters.
  typedef enum logic [1:0] {RGN_ACTIVE, RGN_FP, RGN_SYNC, RGN_BP} vt_region_e;

  // Pixels are {ch2,ch1,ch0} = {R,G,B}.
  function automatic logic [23:0] vt_bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// One video timing axis: counts 0..ACT+FP+SYNC+BP-1 on inc_i, reports the current region
// and a wrap strobe on the increment that returns the count to 0.
module timing_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int ACT  = 8,
  parameter int FP   = 2,
  parameter int SYNC = 3,
  parameter int BP   = 3,
  localparam int TOTAL = ACT + FP + SYNC + BP,
  localparam int CW    = $clog2(TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output vt_region_e    region_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wrap_o  = inc_i && (cnt_q == LAST);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    if (cnt_q < CW'(ACT)) begin
      region_o = RGN_ACTIVE;
    end else if (cnt_q < CW'(ACT + FP)) begin
      region_o = RGN_FP;
    end else if (cnt_q < CW'(ACT + FP + SYNC)) begin
      region_o = RGN_SYNC;
    end else begin
      region_o = RGN_BP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// HDMI video timing sequencer: sync/blank generation and pixel fetch over valid/ready.
// Build option TEST_PATTERN_EN: underflow slots show 8 vertical colour bars instead of black.
module hdmi_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VT_H_ACTIVE,
  parameter int H_FP     = VT_H_FP,
  parameter int H_SYNC   = VT_H_SYNC,
  parameter int H_BP     = VT_H_BP,
  parameter int V_ACTIVE = VT_V_ACTIVE,
  parameter int V_FP     = VT_V_FP,
  parameter int V_SYNC   = VT_V_SYNC,
  parameter int V_BP     = VT_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        i_pix_clk,
  input  logic        reset_n_in,
  input  logic        i_enable,
  input  logic [23:0] i_pix_data,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  input  logic        i_clr_underflow,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_blanking,
  output logic [7:0]  o_data_ch0,
  output logic [7:0]  o_data_ch1,
  output logic [7:0]  o_data_ch2,
  output logic        o_frame_start,
  output logic        o_underflow
);

  // state | meaning
  // IDLE  | counters held at 0, outputs at reset levels
  // RUN   | frames generated back to back
  // DRAIN | enable dropped; finish the current frame, then IDLE

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  vt_state_e     state_q, state_d;
  logic          running, h_wrap, v_wrap, frame_end;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  vt_region_e    h_rgn, v_rgn;
  logic [23:0]   fill_px;

  logic        hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic        fs_q, fs_d, uf_q, uf_d;
  logic [23:0] pix_q, pix_d;

  assign running   = (state_q != IDLE);
  assign frame_end = h_wrap && v_wrap;

  timing_axis_cnt #(.ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .clk_i   (i_pix_clk),
    .rst_n_i (reset_n_in),
    .clr_i   (!running),
    .inc_i   (running),
    .count_o (h_cnt),
    .region_o(h_rgn),
    .wrap_o  (h_wrap)
  );

  timing_axis_cnt #(.ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .clk_i   (i_pix_clk),
    .rst_n_i (reset_n_in),
    .clr_i   (!running),
    .inc_i   (h_wrap),
    .count_o (v_cnt),
    .region_o(v_rgn),
    .wrap_o  (v_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = frame_end ? IDLE : DRAIN;
      DRAIN: begin
        if (i_enable) begin
          state_d = RUN;
        end else if (frame_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready implies running, so it doubles as "this slot is active video".
  assign o_pix_ready = running && (h_rgn == RGN_ACTIVE) && (v_rgn == RGN_ACTIVE);

`ifdef TEST_PATTERN_EN
  assign fill_px = vt_bar_color(3'((int'(h_cnt) * 8) / H_ACTIVE));
`else
  assign fill_px = 24'h000000;
`endif

  always_comb begin
    hsync_d = (running && (h_rgn == RGN_SYNC)) ? HS_POL : ~HS_POL;
    vsync_d = (running && (v_rgn == RGN_SYNC)) ? VS_POL : ~VS_POL;
    blank_d = !o_pix_ready;
    pix_d   = '0;
    if (o_pix_ready) begin
      pix_d = i_pix_valid ? i_pix_data : fill_px;
    end
    fs_d = o_pix_ready && (h_cnt == '0) && (v_cnt == '0);
    uf_d = uf_q;
    if (o_pix_ready && !i_pix_valid) begin
      uf_d = 1'b1;
    end else if (i_clr_underflow) begin
      uf_d = 1'b0;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      blank_q <= 1'b1;
      pix_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      pix_q   <= pix_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_blanking    = blank_q;
  assign o_data_ch0    = pix_q[7:0];
  assign o_data_ch1    = pix_q[15:8];
  assign o_data_ch2    = pix_q[23:16];
  assign o_frame_start = fs_q;
  assign o_underflow   = uf_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Self-checking bench for hdmi_timing_ctrl on a reduced 16x8 raster: a startup vector table,
// directed corner sequences, then randomized traffic against a frame-position reference model.
module tb_hdmi_timing_ctrl;

  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        i_pix_clk = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        i_enable = 1'b0;
  logic [23:0] i_pix_data = '0;
  logic        i_pix_valid = 1'b0;
  logic        o_pix_ready;
  logic        i_clr_underflow = 1'b0;
  logic        o_hsync, o_vsync, o_blanking, o_frame_start, o_underflow;
  logic [7:0]  o_data_ch0, o_data_ch1, o_data_ch2;

  hdmi_timing_ctrl #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .i_pix_clk      (i_pix_clk),
    .reset_n_in     (reset_n_in),
    .i_enable       (i_enable),
    .i_pix_data     (i_pix_data),
    .i_pix_valid    (i_pix_valid),
    .o_pix_ready    (o_pix_ready),
    .i_clr_underflow(i_clr_underflow),
    .o_hsync        (o_hsync),
    .o_vsync        (o_vsync),
    .o_blanking     (o_blanking),
    .o_data_ch0     (o_data_ch0),
    .o_data_ch1     (o_data_ch1),
    .o_data_ch2     (o_data_ch2),
    .o_frame_start  (o_frame_start),
    .o_underflow    (o_underflow)
  );

  always #5 i_pix_clk = ~i_pix_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0=idle 1=run 2=drain, position within the frame, sticky underflow.
  int m_mode  = 0;
  int m_pos   = 0;
  bit m_uf    = 0;
  bit m_known = 0;

  int cyc = 0, last_fs_cyc = -1, fs_period = 0;
  bit last_ready = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] fill_px(input int h);
`ifdef TEST_PATTERN_EN
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[(h * 8) / H_ACT];
`else
    return (h < 0) ? 24'hFFFFFF : 24'h000000;
`endif
  endfunction

  // Called just after a falling edge; returns just after the following falling edge.
  task automatic cycle(input logic rst, input logic en, input logic vld, input logic clr,
                       input logic [23:0] dat);
    int h, v, old;
    bit act, last, e_hs, e_vs;
    logic [23:0] e_data;
    reset_n_in = rst; i_enable = en; i_pix_valid = vld; i_clr_underflow = clr; i_pix_data = dat;
    #1;
    h = m_pos % H_TOT;
    v = m_pos / H_TOT;
    act = (m_mode != 0) && (h < H_ACT) && (v < V_ACT);
    last_ready = o_pix_ready;
    if (m_known) chk("ready", o_pix_ready, act);
    e_hs = 0; e_vs = 0; e_data = '0;
    if (!rst) begin
      act = 0; m_mode = 0; m_pos = 0; m_uf = 0; m_known = 1;
    end else begin
      e_hs = (m_mode != 0) && (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
      e_vs = (m_mode != 0) && (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
      if (act) e_data = vld ? dat : fill_px(h);
      if (act && !vld) m_uf = 1;
      else if (clr) m_uf = 0;
      last = (m_pos == FRAME - 1);
      old = m_mode;
      case (m_mode)
        0: if (en) m_mode = 1;
        1: if (!en) m_mode = last ? 0 : 2;
        default: if (en) m_mode = 1; else if (last) m_mode = 0;
      endcase
      m_pos = (old == 0) ? 0 : (m_pos + 1) % FRAME;
    end
    @(posedge i_pix_clk);
    #1;
    cyc++;
    if (m_known) begin
      chk("hsync", o_hsync, e_hs);
      chk("vsync", o_vsync, e_vs);
      chk("blanking", o_blanking, !act);
      chk("data", {o_data_ch2, o_data_ch1, o_data_ch0}, e_data);
      chk("frame_start", o_frame_start, act && (rst && (m_pos == 1)) && (h == 0) && (v == 0));
      chk("underflow", o_underflow, m_uf);
    end
    if (o_frame_start === 1'b1) begin
      if (last_fs_cyc >= 0) fs_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
    end
    @(negedge i_pix_clk);
  endtask

  typedef struct {
    logic rst, en;
    logic rdy, blank, fs, hs;
  } vec_t;

  vec_t vecs [17];
  int   cnt = 1;
  int   px;

  initial begin
    vecs = '{
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // reset held
      '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},  // reset dominates enable
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},  // enable sampled -> RUN at h=0
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},  // pixel (0,0) on outputs
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // output h=7, ready off at h=8
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},  // h=10 sync
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}   // h=13 back porch
    };

    @(negedge i_pix_clk);

    // Startup table
    for (int k = 0; k < 17; k++) begin
      cycle(vecs[k].rst, vecs[k].en, 1'b1, 1'b0, 24'(cnt));
      cnt++;
      chk($sformatf("vec%0d_ready", k), o_pix_ready, vecs[k].rdy);
      chk($sformatf("vec%0d_blank", k), o_blanking, vecs[k].blank);
      chk($sformatf("vec%0d_fs", k), o_frame_start, vecs[k].fs);
      chk($sformatf("vec%0d_hsync", k), o_hsync, vecs[k].hs);
    end

    // Incrementing source, two full frames
    px = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
      if (last_ready) cnt++;
      if (k < FRAME) px += int'(last_ready);
    end
    chk("pixels_per_frame", 32'(px), 32'd32);
    chk("frame_period", 32'(fs_period), 32'd128);
    chk("no_underflow", o_underflow, 1'b0);

    // Missed slot at pixel 3 of line 1
    for (int k = 0; k < 300 && m_pos != H_TOT + 3; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
      if (last_ready) cnt++;
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'(cnt));
    chk("miss_data", {o_data_ch2, o_data_ch1, o_data_ch0}, fill_px(3));
    chk("miss_uf_set", o_underflow, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
    chk("after_miss_data", {o_data_ch2, o_data_ch1, o_data_ch0}, 24'(cnt));
    cnt++;
    chk("uf_sticky", o_underflow, 1'b1);

    // Clear and new underflow together, then clear alone
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 24'(cnt));
    chk("set_beats_clear", o_underflow, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 24'(cnt));
    cnt++;
    chk("clear_alone", o_underflow, 1'b0);

    // Enable dropped at v=1, h=4: drain to the end of the frame
    for (int k = 0; k < 300 && m_pos != H_TOT + 4; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
      if (last_ready) cnt++;
    end
    px = 0;
    for (int k = 0; k < FRAME - (H_TOT + 4); k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'(cnt));
      if (last_ready) cnt++;
      px += int'(last_ready);
    end
    chk("drain_pixels", 32'(px), 32'd20);
    chk("idle_ready", o_pix_ready, 1'b0);
    chk("idle_blank", o_blanking, 1'b1);
    chk("idle_hsync", o_hsync, 1'b0);
    chk("idle_vsync", o_vsync, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'(cnt));
    chk("still_idle_ready", o_pix_ready, 1'b0);

    // Reset pulsed mid-line with underflow set
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
    for (int k = 0; k < 300 && m_pos != 2 * H_TOT + 2; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
      if (last_ready) cnt++;
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'(cnt));
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
    cnt++;
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 24'(cnt));
    chk("rst_ready", o_pix_ready, 1'b0);
    chk("rst_blank", o_blanking, 1'b1);
    chk("rst_hsync", o_hsync, 1'b0);
    chk("rst_data", {o_data_ch2, o_data_ch1, o_data_ch0}, 24'h0);
    chk("rst_uf", o_underflow, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'(cnt));
    chk("restart_ready", o_pix_ready, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 24'h5A5A5A);
    chk("restart_fs", o_frame_start, 1'b1);
    chk("restart_data", {o_data_ch2, o_data_ch1, o_data_ch0}, 24'h5A5A5A);

    // Randomized traffic against the model
    begin
      logic ren;
      ren = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(149) == 0) ren = ~ren;
        cycle(($urandom_range(199) != 0), ren, ($urandom_range(7) != 0),
              ($urandom_range(15) == 0), 24'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
